// File: rtl/wave_pwm_gen_pkg.sv
// Shared definitions for the waveform/PWM generator: wave selector encoding
// and default widths.
package wave_pwm_gen_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DIV_W_DEF  = 5;
  localparam int unsigned AMP_W_DEF  = 2;

  typedef enum logic [2:0] {
    WAVE_SQUARE  = 3'd0,
    WAVE_TRI     = 3'd1,
    WAVE_RAMP_UP = 3'd2,
    WAVE_RAMP_DN = 3'd3,
    WAVE_OFF     = 3'd4
  } wave_e;

  // Codes 4-7 all collapse to off so the latched mode is always a legal enum.
  function automatic wave_e decode_wave(input logic [2:0] w);
    wave_e m;
    case (w)
      3'd0:    m = WAVE_SQUARE;
      3'd1:    m = WAVE_TRI;
      3'd2:    m = WAVE_RAMP_UP;
      3'd3:    m = WAVE_RAMP_DN;
      default: m = WAVE_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/wave_pwm_gen_pwm_modulator.sv
// PWM output stage: free-running counter, duty latched only at the counter
// wrap so a sample change never disturbs the period in progress.
module pwm_modulator #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  output logic              pwm_out
);

  logic [DATA_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DATA_W-1:0] pwm_duty_q, pwm_duty_d;
  logic              pwm_out_q, pwm_out_d;

  always_comb begin
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    pwm_duty_d = (pwm_cnt_q == '1) ? sample : pwm_duty_q;
    pwm_out_d  = (pwm_cnt_q < pwm_duty_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt_q  <= '0;
      pwm_duty_q <= '0;
      pwm_out_q  <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_duty_q <= pwm_duty_d;
      pwm_out_q  <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;

endmodule

// File: rtl/wave_pwm_gen.sv
// Single-channel waveform generator: loadable tick divider, phase
// accumulator, wrap-synchronous mode latch, shaping/scaling and PWM output.
module wave_pwm_gen
  import wave_pwm_gen_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned AMP_W  = AMP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key,
  input  logic [DIV_W-1:0]  ParIn,
  input  logic [2:0]        WaveType,
  input  logic [AMP_W-1:0]  AmpSel,
  input  logic [DATA_W-1:0] Duty,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              pwm_out
);

  logic              key_d_q;
  logic [DIV_W-1:0]  div_reg_q, div_reg_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [DATA_W-1:0] phase_q, phase_d;
  wave_e             mode_q, mode_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;

  logic              load, tick;
  logic [DATA_W-1:0] tri_t, raw, scaled;

  // A load restarts the divider and swallows any tick due in that cycle.
  always_comb begin
    load      = key & ~key_d_q;
    tick      = 1'b0;
    div_reg_d = div_reg_q;
    div_cnt_d = div_cnt_q + 1'b1;
    if (load) begin
      div_reg_d = ParIn;
      div_cnt_d = '0;
    end else if (div_cnt_q == div_reg_q) begin
      tick      = 1'b1;
      div_cnt_d = '0;
    end
    phase_d = tick ? phase_q + 1'b1 : phase_q;
    mode_d  = (tick && (phase_q == '1)) ? decode_wave(WaveType) : mode_q;
  end

  always_comb begin
    tri_t = {phase_q[DATA_W-2:0], 1'b0};
    case (mode_q)
      WAVE_SQUARE:  raw = (phase_q < Duty) ? '1 : '0;
      WAVE_TRI:     raw = phase_q[DATA_W-1] ? ~tri_t : tri_t;
      WAVE_RAMP_UP: raw = phase_q;
      WAVE_RAMP_DN: raw = ~phase_q;
      default:      raw = '0;
    endcase
    scaled         = raw >> AmpSel;
    sample_d       = tick ? scaled : sample_q;
    sample_valid_d = tick;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_d_q        <= 1'b0;
      div_reg_q      <= '0;
      div_cnt_q      <= '0;
      phase_q        <= '0;
      mode_q         <= WAVE_SQUARE;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      key_d_q        <= key;
      div_reg_q      <= div_reg_d;
      div_cnt_q      <= div_cnt_d;
      phase_q        <= phase_d;
      mode_q         <= mode_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;

  pwm_modulator #(
    .DATA_W(DATA_W)
  ) u_pwm (
    .clk    (clk),
    .reset  (reset),
    .sample (sample_q),
    .pwm_out(pwm_out)
  );

endmodule

// File: tb/tb_wave_pwm_gen.sv
// Scoreboard bench for wave_pwm_gen: a behavioural model predicts each
// sample update and each PWM output bit; monitors compare on DUT output.
module tb_wave_pwm_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key = 1'b0;
  logic [4:0] ParIn = '0;
  logic [2:0] WaveType = '0;
  logic [1:0] AmpSel = '0;
  logic [7:0] Duty = '0;
  logic [7:0] sample;
  logic       sample_valid;
  logic       pwm_out;

  always #5 clk = ~clk;

  wave_pwm_gen #(
    .DATA_W(8),
    .DIV_W (5),
    .AMP_W (2)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .key         (key),
    .ParIn       (ParIn),
    .WaveType    (WaveType),
    .AmpSel      (AmpSel),
    .Duty        (Duty),
    .sample      (sample),
    .sample_valid(sample_valid),
    .pwm_out     (pwm_out)
  );

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t smp_q[$];
  exp_t pwm_q[$];
  int   errors = 0;
  int   checks = 0;
  int   c = 0;
  logic running = 1'b0;

  // Model state: ticks fall every m_per cycles after the last load at m_t0.
  int   m_t0, m_per, m_phase, m_mode, m_sample, m_duty;
  logic m_keyp;

  function automatic int shape(input int p, input int mode, input int amp, input int duty);
    int raw;
    case (mode)
      0:       raw = (p < duty) ? 255 : 0;
      1:       raw = (p < 128) ? 2 * p : 2 * (255 - p) + 1;
      2:       raw = p;
      3:       raw = 255 - p;
      default: raw = 0;
    endcase
    return raw / (1 << amp);
  endfunction

  task automatic model_init();
    smp_q.delete();
    pwm_q.delete();
    c        = 0;
    m_t0     = -1;
    m_per    = 1;
    m_phase  = 0;
    m_mode   = 0;
    m_sample = 0;
    m_duty   = 0;
    m_keyp   = 1'b0;
    running  = 1'b1;
    rst_n    = 1'b1;
  endtask

  task automatic model_cycle();
    logic load, tick;
    int   j;
    exp_t e;
    load   = key && !m_keyp;
    m_keyp = key;
    if (load) begin
      m_per = int'(ParIn) + 1;
      m_t0  = c;
      tick  = 1'b0;
    end else begin
      tick = ((c - m_t0) % m_per) == 0;
    end
    j     = c % 256;
    e.cyc = c;
    e.val = (j < m_duty) ? 1 : 0;
    pwm_q.push_back(e);
    if (j == 255) m_duty = m_sample;
    if (tick) begin
      e.val = shape(m_phase, m_mode, int'(AmpSel), int'(Duty));
      smp_q.push_back(e);
      m_sample = e.val;
      if (m_phase == 255) m_mode = int'(WaveType);
      m_phase = (m_phase + 1) % 256;
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    if (running && rst_n) begin
      while (smp_q.size() > 0 && smp_q[0].cyc < c - 1) begin
        checks++;
        errors++;
        $display("FAIL missed_valid cyc=%0d got valid=0 required valid=1", smp_q[0].cyc);
        void'(smp_q.pop_front());
      end
      if (sample_valid) begin
        checks++;
        if (smp_q.size() == 0 || smp_q[0].cyc != c - 1) begin
          errors++;
          $display("FAIL spurious_valid cyc=%0d got valid=1 required valid=0", c - 1);
        end else begin
          exp_t e;
          e = smp_q.pop_front();
          checks++;
          if (int'(sample) != e.val) begin
            errors++;
            $display("FAIL sample cyc=%0d got=%0d required=%0d", e.cyc, sample, e.val);
          end
        end
      end
      if (pwm_q.size() > 0 && pwm_q[0].cyc == c - 1) begin
        exp_t e;
        e = pwm_q.pop_front();
        checks++;
        if (int'(pwm_out) != e.val) begin
          errors++;
          $display("FAIL pwm_out cyc=%0d got=%0d required=%0d", e.cyc, pwm_out, e.val);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (sample !== 8'd0 || sample_valid !== 1'b0 || pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL %s got sample=%0d valid=%0d pwm=%0d required 0/0/0",
               tag, sample, sample_valid, pwm_out);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_initial");
    WaveType = 3'd1;
    model_init();

    // Triangle across more than one full period after the first wrap.
    run(600);

    // Ramp up, then request ramp down mid-period.
    WaveType = 3'd2;
    run(300);
    WaveType = 3'd3;
    run(400);

    // Square with amplitude scaling, zero duty, then a steady mid-level sample.
    WaveType = 3'd0;
    Duty     = 8'd64;
    AmpSel   = 2'd2;
    run(600);
    Duty = 8'd0;
    run(300);
    Duty   = 8'd255;
    AmpSel = 2'd1;
    run(700);

    // Single key pulse, then a long key hold with ParIn changing underneath.
    ParIn = 5'd3;
    key   = 1'b1;
    step();
    key = 1'b0;
    run(40);
    ParIn = 5'd3;
    key   = 1'b1;
    run(3);
    ParIn = 5'd7;
    run(7);
    key = 1'b0;
    run(40);

    // Asynchronous reset mid-operation.
    rst_n   = 1'b0;
    running = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    ParIn    = 5'd0;
    WaveType = 3'd2;
    AmpSel   = 2'd0;
    model_init();
    run(300);

    // Randomised mix of loads, mode requests, scaling and duty.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) key = ~key;
      if ($urandom_range(0, 19) == 0) ParIn = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) WaveType = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) AmpSel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) Duty = 8'($urandom_range(0, 255));
      step();
    end

    @(negedge clk);
    #1;
    running = 1'b0;
    checks++;
    if (smp_q.size() != 0) begin
      errors++;
      $display("FAIL sample_queue_drain got=%0d required=0", smp_q.size());
    end
    checks++;
    if (pwm_q.size() != 0) begin
      errors++;
      $display("FAIL pwm_queue_drain got=%0d required=0", pwm_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_pwm_gen.md
Name: wave_pwm_gen

Overview:
- Parametrised single-channel waveform generator with a PWM output stage. It extends the fixed square/triangle/ramp generator with:
  - a runtime-loadable frequency divider
  - a down-ramp mode
  - an off mode
  - a programmable square-wave duty
  - glitch-free mode changes
  - amplitude scaling
- Sits between the key/switch front end and the audio/LED PWM pin.

Parameters:
- DATA_W, 8, sample, phase and PWM counter width
- DIV_W, 5, divider reload width (width of ParIn)
- AMP_W, 2, amplitude shift-select width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- key  input  1  load strobe, synchronous to clk; its rising edge loads ParIn
- ParIn  input  DIV_W  divider reload value
- WaveType  input  3  requested waveform: 0 square, 1 triangle, 2 ramp up, 3 ramp down, 4-7 off
- AmpSel  input  AMP_W  amplitude attenuation, output right-shifted by AmpSel
- Duty  input  DATA_W  square-wave high threshold
- sample  output  DATA_W  current shaped, scaled sample
- sample_valid  output  1  one-cycle pulse when sample updates
- pwm_out  output  1  PWM-modulated sample

Behaviour:
- Reset (reset=0, asynchronous): all of the following clear to 0 immediately, mid-operation included:
  - div_reg, div_cnt, phase, mode, key_d
  - sample, sample_valid
  - pwm_cnt, pwm_duty, pwm_out
- Key edge:
  - key_d <= key; load = key & ~key_d.
  - On load: div_reg <= ParIn and div_cnt <= 0.
  - A key held high loads exactly once.
- Divider:
  - If div_cnt == div_reg: tick=1 and div_cnt <= 0; else div_cnt <= div_cnt+1.
  - Tick period is div_reg+1 clocks; div_reg=0 gives a tick every clock.
  - A load takes priority over the increment in the same cycle, and suppresses the tick in that cycle.
- Phase: on tick, phase <= phase+1, wrapping from 2^DATA_W-1 to 0.
- Mode latch:
  - mode <= WaveType only on a tick where phase == 2^DATA_W-1 (the wrap edge).
  - Mode changes therefore never occur mid-period.
  - Mode is 0 (square) after reset.
- Shaping (combinational, from registered phase; M = 2^DATA_W-1):
  - square: phase < Duty ? M : 0. Duty=0 gives constant 0.
  - triangle: t = {phase[DATA_W-2:0],1'b0}; raw = phase[MSB] ? ~t : t.
  - ramp up: raw = phase. Ramp down: raw = ~phase. Off (4-7): raw = 0.
  - scaled = raw >> AmpSel (logical shift, no rounding).
- Sample stage:
  - Registered, latency 1: the cycle after a tick, sample <= scaled and sample_valid=1 for one cycle.
  - Otherwise sample holds and sample_valid=0.
- PWM:
  - pwm_cnt increments every clock and wraps.
  - When pwm_cnt == M: pwm_duty <= sample, latched at the wrap only, so no glitch.
  - pwm_out <= (pwm_cnt < pwm_duty), registered.
  - pwm_duty=0 gives constant low; pwm_duty=M gives high for M of every 2^DATA_W clocks.
- Simultaneous events:
  - load and the phase wrap in the same cycle: the load wins, no tick, mode not latched.
  - WaveType changes are ignored until the next wrap.
  - AmpSel and Duty act combinationally on the next sample update.

Decomposition:
- Shared package holds:
  - wave-type constants: WAVE_SQUARE=0, WAVE_TRI=1, WAVE_RAMP_UP=2, WAVE_RAMP_DN=3, WAVE_OFF=4
  - default widths
- One natural sub-module: pwm_modulator, parametrised by DATA_W. It contains pwm_cnt, the duty latch and the comparator; inputs are clk, reset and sample; output is pwm_out.
- Divider, phase and shaping stay in the top module.

Test Plan:
- Reset/defaults:
  - hold reset=0 for 3 clocks mid-run -> sample=0, sample_valid=0, pwm_out=0 within the same cycle.
  - after release with no key: tick every clock, so sample_valid is high every cycle from the 2nd cycle.
- Divider load:
  - pulse key with ParIn=3 -> sample_valid pulses every 4 clocks.
  - hold key high for 10 clocks with ParIn changing from 3 to 7 -> period stays 4, because there is only one load.
- Triangle (ParIn=0, WaveType=1 set before the first wrap, AmpSel=0):
  - after the wrap, phase 64 -> sample 128, phase 127 -> 254, phase 128 -> 255, phase 255 -> 1.
- Glitch-free mode change:
  - switch WaveType from 2 to 3 at phase 100 -> samples continue ramping up until phase 255.
  - the sample for phase 0 after the wrap is 255 (ramp down).
- Square plus amplitude:
  - Duty=64, AmpSel=2 -> sample=63 for phases 0-63 and 0 for phases 64-255.
  - Duty=0 -> sample constantly 0.
- PWM:
  - force sample=128 steady -> pwm_out high for 128 of each 256 clocks, beginning after the next pwm_cnt wrap.
  - sample=0 -> pwm_out never high.
  - a sample change mid PWM period does not alter the current period.
